// File: rtl/fir_unfolded_param.sv
// fir_unfolded_param: J-way unfolded direct-form FIR filter.
// Each valid cycle accepts J consecutive samples and produces J outputs.
// Two pipeline stages: input register, then sum register into DOUT.
// Optional build macro FIR_UNFOLD_SAT_EN: saturate each result to NBIT
// instead of wrapping to the low NBIT bits.
//
// Handshake: a lane group is transferred on every cycle VIN is high; there
// is no ready/backpressure. VOUT marks DOUT valid exactly two cycles after
// the matching VIN, and the sink must accept every VOUT cycle. DOUT holds
// its last value while VOUT is low. RST wins over VIN.
module fir_unfolded_param #(
    parameter int NBIT  = 9,
    parameter int NTAPS = 9,
    parameter int J     = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  VIN,
    input  logic [J*NBIT-1:0]     DIN,
    input  logic [NTAPS*NBIT-1:0] B,
    output logic [J*NBIT-1:0]     DOUT,
    output logic                  VOUT
);

    // H samples of history are enough to cover the oldest tap of lane 0.
    localparam int H    = NTAPS - 1;
    localparam int W    = H + J;
    localparam int PW   = 2 * NBIT;
    localparam int ACCW = 2 * NBIT + $clog2(NTAPS);

`ifdef FIR_UNFOLD_SAT_EN
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(2 ** (NBIT - 1) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = -SAT_MAX - 1;
`endif

    logic [J*NBIT-1:0]      din_r;
    logic                   vin_r;
    // hist[0] is the most recent sample before the current group.
    logic signed [NBIT-1:0] hist [H];
    // win[p] in time order: win[0] oldest history sample, win[W-1] newest lane.
    logic signed [NBIT-1:0] win  [W];
    logic signed [NBIT-1:0] coef [NTAPS];
    logic signed [ACCW-1:0] acc  [J];
    logic [J*NBIT-1:0]      sum_w;

    // Full-precision signed product.
    function automatic logic signed [PW-1:0] mul(input logic signed [NBIT-1:0] a,
                                                 input logic signed [NBIT-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    // Floor shift back to Q1.(NBIT-1), then wrap or saturate to NBIT.
    function automatic logic [NBIT-1:0] reduce(input logic signed [ACCW-1:0] a);
`ifdef FIR_UNFOLD_SAT_EN
        logic signed [ACCW-1:0] s;
        s = a >>> (NBIT - 1);
        if (s > SAT_MAX)
            return NBIT'(SAT_MAX);
        else if (s < SAT_MIN)
            return NBIT'(SAT_MIN);
        else
            return NBIT'(s);
`else
        return NBIT'(a >>> (NBIT - 1));
`endif
    endfunction

    // Stage 1: register the incoming lane group and its valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            din_r <= '0;
            vin_r <= 1'b0;
        end else begin
            vin_r <= VIN;
            if (VIN)
                din_r <= DIN;
        end
    end

    // Assemble the time-ordered sample window and unpack the coefficients.
    always_comb begin
        for (int p = 0; p < H; p++)
            win[p] = hist[H-1-p];
        for (int j = 0; j < J; j++)
            win[H+j] = $signed(din_r[j*NBIT +: NBIT]);
        for (int i = 0; i < NTAPS; i++)
            coef[i] = $signed(B[i*NBIT +: NBIT]);
    end

    // One full-precision dot product per lane; lane j sees taps win[H+j-i].
    always_comb begin
        for (int j = 0; j < J; j++) begin
            acc[j] = '0;
            for (int i = 0; i < NTAPS; i++)
                acc[j] = acc[j] + ACCW'(mul(coef[i], win[H+j-i]));
        end
    end

    // Scale and reduce every lane to the output width.
    always_comb begin
        sum_w = '0;
        for (int j = 0; j < J; j++)
            sum_w[j*NBIT +: NBIT] = reduce(acc[j]);
    end

    // Stage 2: capture sums and advance the history only on valid groups,
    // so idle cycles leave both untouched.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT <= '0;
            VOUT <= 1'b0;
            for (int h = 0; h < H; h++)
                hist[h] <= '0;
        end else begin
            VOUT <= vin_r;
            if (vin_r) begin
                DOUT <= sum_w;
                for (int h = 0; h < H; h++)
                    hist[h] <= win[W-1-h];
            end
        end
    end

endmodule
